// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared encodings and helpers for the round-robin AHB arbiter.
package ahb_rr_arbiter_pkg;

  // HTRANS encodings as seen on the post-mux slave side.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Arbiter tenure states.
  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Master that receives the bus when nobody is asking for it.
  localparam int DEFAULT_MASTER = 0;

  // Quota counter width; wide enough for quotas up to 15.
  localparam int CNT_W = 4;

  // Ownership may only move while no burst is in flight and the slave is ready.
  function automatic logic is_arb_point(input logic       hready,
                                        input logic [1:0] htrans);
    return hready && (htrans != HTRANS_SEQ) && (htrans != HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating priority encoder: first requester after ptr_i, wrapping, with ptr_i
// itself visited last. Index 0 is returned when nobody requests.
module ahb_rr_pick #(
  parameter int NUM_M = 3,
  parameter int MW    = 2
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [MW-1:0]    ptr_i,
  output logic [MW-1:0]    idx_o,
  output logic             valid_o
);

  logic [MW-1:0] cand;
  logic [MW-1:0] idx_sel;
  logic          found;

  // Walk the ring starting one past the current owner and keep the first hit.
  always_comb begin
    cand    = '0;
    idx_sel = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = MW'((int'(ptr_i) + k) % NUM_M);
      if (!found && req_i[cand]) begin
        idx_sel = cand;
        found   = 1'b1;
      end
    end
  end

  assign idx_o   = idx_sel;
  assign valid_o = found;

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin, quota-limited AHB arbiter. Grant moves only at arbitration
// points, bursts and locked sequences are never broken, and an owner is
// rotated out after QUOTA NONSEQ transfers if someone else is waiting.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  PARK   | nobody requesting, grant parked on the default master
//  OWN    | unlocked tenure, subject to quota and round-robin rotation
//  LOCKED | locked tenure, grant held until owner drops HLOCK at an AP
module ahb_rr_arbiter
  import ahb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int QUOTA = 4,
  parameter int MW    = $clog2(NUM_M)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NUM_M-1:0] HBUSREQ,
  input  logic [NUM_M-1:0] HLOCK,
  input  logic [1:0]       HTRANS_S,
  input  logic             HREADY_S,
  output logic [NUM_M-1:0] HGRANT,
  output logic [MW-1:0]    HMASTER,
  output logic [MW-1:0]    HMASTER_D,
  output logic             HMASTLOCK
);

  localparam logic [NUM_M-1:0] GRANT_RST = NUM_M'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]    MASTER_RST = MW'(DEFAULT_MASTER);
  localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [MW-1:0]    master_q;
  logic [MW-1:0]    data_owner_q;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ap;
  logic [MW-1:0]    grant_idx;
  logic [MW-1:0]    pick_idx;
  logic             pick_valid;
  logic [NUM_M-1:0] pick_oh;
  logic [NUM_M-1:0] master_oh;
  logic             own_req;
  logic             own_lock;
  logic             others_req;
  logic             eval_own;

  // Rotation is always relative to the current address-phase owner.
  ahb_rr_pick #(
    .NUM_M (NUM_M),
    .MW    (MW)
  ) u_pick (
    .req_i   (HBUSREQ),
    .ptr_i   (master_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign ap         = is_arb_point(HREADY_S, HTRANS_S);
  assign pick_oh    = NUM_M'(1) << pick_idx;
  assign master_oh  = NUM_M'(1) << master_q;
  assign own_req    = |(HBUSREQ & master_oh);
  assign own_lock   = |(HLOCK & master_oh);
  assign others_req = |(HBUSREQ & ~master_oh);

  // Decode the one-hot grant back to an index for the owner pipeline.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        grant_idx = MW'(i);
      end
    end
  end

  // Tenure FSM: next state and next grant, evaluated only at arbitration points.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    eval_own = 1'b0;
    if (ap) begin
      unique case (state_q)
        ST_PARK: begin
          if (pick_valid) begin
            state_d = ST_OWN;
            grant_d = pick_oh;
          end
        end
        ST_OWN: begin
          eval_own = 1'b1;
        end
        ST_LOCKED: begin
          // Leaving a lock falls straight through into the unlocked decision.
          eval_own = !own_lock;
        end
        default: begin
          state_d = ST_PARK;
          grant_d = GRANT_RST;
        end
      endcase

      if (eval_own) begin
        if (own_lock && own_req) begin
          state_d = ST_LOCKED;
        end else if (own_req && ((cnt_q < QUOTA_C) || !others_req)) begin
          state_d = ST_OWN;
        end else begin
          grant_d = pick_oh;
          state_d = pick_valid ? ST_OWN : ST_PARK;
        end
      end
    end
  end

  // Quota count of completed NONSEQ transfers by the current owner.
  always_comb begin
    cnt_d = cnt_q;
    if (HREADY_S) begin
      if (grant_idx != master_q) begin
        cnt_d = '0;
      end else if ((HTRANS_S == HTRANS_NONSEQ) && (cnt_q < QUOTA_C)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Locked indication follows the granted master while a lock is held or starting.
  always_comb begin
    lock_d = HLOCK[grant_idx] &&
             ((state_q == ST_LOCKED) || (state_d == ST_LOCKED));
  end

  // State and grant registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_PARK;
      grant_q <= GRANT_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Owner pipeline advances only on ready edges so wait states never move it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      master_q     <= MASTER_RST;
      data_owner_q <= MASTER_RST;
      lock_q       <= 1'b0;
    end else if (HREADY_S) begin
      master_q     <= grant_idx;
      data_owner_q <= master_q;
      lock_q       <= lock_d;
    end
  end

  // Quota counter register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTER_D = data_owner_q;
  assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed and random stimulus for ahb_rr_arbiter with a cycle-level
// reference model feeding a scoreboard queue.
module tb_ahb_rr_arbiter;
  import ahb_rr_arbiter_pkg::*;

  localparam int N = 3;
  localparam int Q = 4;
  localparam int M_PARK   = 0;
  localparam int M_OWN    = 1;
  localparam int M_LOCKED = 2;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS_S;
  logic         HREADY_S;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic [1:0]   HMASTER_D;
  logic         HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_rr_arbiter #(
    .NUM_M (N),
    .QUOTA (Q),
    .MW    (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS_S  (HTRANS_S),
    .HREADY_S  (HREADY_S),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  int   md_state, md_grant, md_master, md_master_d, md_cnt;
  bit   md_lock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hgrant"},    8'(HGRANT),    8'h01);
    check({tag, "_hmaster"},   8'(HMASTER),   8'h00);
    check({tag, "_hmaster_d"}, 8'(HMASTER_D), 8'h00);
    check({tag, "_hmastlock"}, 8'(HMASTLOCK), 8'h00);
  endtask

  task automatic model_reset();
    md_state    = M_PARK;
    md_grant    = 0;
    md_master   = 0;
    md_master_d = 0;
    md_cnt      = 0;
    md_lock     = 1'b0;
    sb.delete();
  endtask

  // One clock of the arbiter as described: decisions use the address-phase owner.
  task automatic model_step(input logic [2:0] req, input logic [2:0] lock,
                            input logic [1:0] tr, input logic rdy);
    bit   ap, own_req, own_lock, others, found, eval_own;
    int   pk, ns, ng;
    exp_t e;
    ap       = rdy && (tr == 2'b10 || tr == 2'b00);
    own_req  = req[md_master];
    own_lock = lock[md_master];
    others   = 1'b0;
    for (int i = 0; i < N; i++) if (i != md_master && req[i]) others = 1'b1;
    found = 1'b0;
    pk    = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (md_master + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        pk    = c;
      end
    end
    ns       = md_state;
    ng       = md_grant;
    eval_own = 1'b0;
    if (ap) begin
      if (md_state == M_PARK) begin
        if (found) begin
          ns = M_OWN;
          ng = pk;
        end
      end else if (md_state == M_OWN) begin
        eval_own = 1'b1;
      end else if (!own_lock) begin
        eval_own = 1'b1;
      end
      if (eval_own) begin
        if (own_lock && own_req) begin
          ns = M_LOCKED;
        end else if (own_req && (md_cnt < Q || !others)) begin
          ns = M_OWN;
        end else begin
          ng = pk;
          ns = found ? M_OWN : M_PARK;
        end
      end
    end
    if (rdy) begin
      md_lock     = lock[md_grant] && (md_state == M_LOCKED || ns == M_LOCKED);
      md_master_d = md_master;
      if (md_grant != md_master) md_cnt = 0;
      else if (tr == 2'b10 && md_cnt < Q) md_cnt = md_cnt + 1;
      md_master = md_grant;
    end
    md_state = ns;
    md_grant = ng;
    e.g  = 3'(1 << md_grant);
    e.m  = 2'(md_master);
    e.md = 2'(md_master_d);
    e.l  = md_lock;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [2:0] req, input logic [2:0] lock,
                      input logic [1:0] tr, input logic rdy);
    exp_t e;
    HBUSREQ  = req;
    HLOCK    = lock;
    HTRANS_S = tr;
    HREADY_S = rdy;
    model_step(req, lock, tr, rdy);
    @(posedge HCLK);
    #1;
    e = sb.pop_front();
    check("hgrant",    8'(HGRANT),    8'(e.g));
    check("hmaster",   8'(HMASTER),   8'(e.m));
    check("hmaster_d", 8'(HMASTER_D), 8'(e.md));
    check("hmastlock", 8'(HMASTLOCK), 8'(e.l));
    check("onehot",    8'($onehot(HGRANT)), 8'd1);
    @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET   = 1'b1;
    HBUSREQ  = 3'b111;
    HLOCK    = 3'b000;
    HTRANS_S = HTRANS_IDLE;
    HREADY_S = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check_reset_vals("reset");
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();

    // Rotation with everyone requesting.
    repeat (16) step(3'b111, 3'b000, HTRANS_NONSEQ, 1'b1);
    for (int i = 0; i < 8; i++)
      step(3'b111, 3'b000, (i % 2 == 1) ? HTRANS_IDLE : HTRANS_NONSEQ, 1'b1);

    // Reset in the middle of a burst.
    HRESET   = 1'b1;
    HTRANS_S = HTRANS_SEQ;
    #1;
    check_reset_vals("midreset");
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();

    // Quota: M0 alone, then M1 joins while M0 streams NONSEQ.
    step(3'b001, 3'b000, HTRANS_NONSEQ, 1'b1);
    step(3'b011, 3'b000, HTRANS_NONSEQ, 1'b1);
    step(3'b011, 3'b000, HTRANS_NONSEQ, 1'b1);
    step(3'b011, 3'b000, HTRANS_NONSEQ, 1'b1);
    check("quota_hold", 8'(HGRANT), 8'h01);
    step(3'b011, 3'b000, HTRANS_NONSEQ, 1'b1);
    check("quota_rotate", 8'(HGRANT), 8'h02);

    // Burst integrity: M1 INCR4 with a wait state, dropping its request mid-burst.
    step(3'b110, 3'b000, HTRANS_IDLE,   1'b1);
    step(3'b110, 3'b000, HTRANS_NONSEQ, 1'b1);
    step(3'b110, 3'b000, HTRANS_SEQ,    1'b1);
    step(3'b110, 3'b000, HTRANS_SEQ,    1'b0);
    step(3'b100, 3'b000, HTRANS_SEQ,    1'b1);
    step(3'b100, 3'b000, HTRANS_SEQ,    1'b1);
    check("burst_hold", 8'(HGRANT), 8'h02);
    step(3'b100, 3'b000, HTRANS_IDLE,   1'b1);
    check("burst_end", 8'(HGRANT), 8'h04);

    // Lock: M2 holds HLOCK for six transfers while M0 and M1 wait.
    step(3'b101, 3'b000, HTRANS_IDLE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 3'b100, (i == 4) ? HTRANS_SEQ : HTRANS_NONSEQ, 1'b1);
      check("lock_grant", 8'(HGRANT),    8'h04);
      check("lock_flag",  8'(HMASTLOCK), 8'h01);
    end
    step(3'b011, 3'b000, HTRANS_IDLE, 1'b1);
    check("unlock_grant", 8'(HGRANT),    8'h01);
    check("unlock_flag",  8'(HMASTLOCK), 8'h00);

    // Wait states during the handover to M0.
    for (int i = 0; i < 3; i++) begin
      step(3'b011, 3'b000, HTRANS_IDLE, 1'b0);
      check("wait_hmaster",   8'(HMASTER),   8'h02);
      check("wait_hmaster_d", 8'(HMASTER_D), 8'h02);
    end
    step(3'b011, 3'b000, HTRANS_IDLE, 1'b1);
    check("wait_release", 8'(HMASTER), 8'h00);

    // Locked tenure ending with nobody requesting parks on master 0.
    step(3'b001, 3'b001, HTRANS_NONSEQ, 1'b1);
    step(3'b001, 3'b001, HTRANS_NONSEQ, 1'b1);
    step(3'b001, 3'b001, HTRANS_NONSEQ, 1'b1);
    step(3'b000, 3'b000, HTRANS_IDLE,   1'b1);
    check("park_after_lock", 8'(HGRANT), 8'h01);
    step(3'b010, 3'b000, HTRANS_IDLE,   1'b1);
    step(3'b010, 3'b000, HTRANS_IDLE,   1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] r, lk;
      r  = 3'($urandom_range(0, 7));
      lk = r & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      step(r, lk, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    // Drain to idle.
    repeat (3) step(3'b000, 3'b000, HTRANS_IDLE, 1'b1);
    check("final_park", 8'(HGRANT), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
